// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon 128/128 block controller.
package simon_pkg;

   localparam int WORD_W         = 64;
   localparam int NUM_ROUNDS_DEF = 68;
   localparam int Z_LEN          = 62;
   localparam int CNT_W          = 7;

   localparam logic [WORD_W-1:0] C = 64'hFFFF_FFFF_FFFF_FFFC;

   // Written first-bit-leftmost, so sequence element i lives at bit Z_LEN-1-i.
   localparam logic [Z_LEN-1:0] Z2 =
      62'b10101111011100000011010010011000101000010001111110010110110011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   function automatic logic z2_bit(input logic [CNT_W-1:0] i);
      logic [CNT_W-1:0] idx;
      idx = i % CNT_W'(Z_LEN);
      return Z2[6'(CNT_W'(Z_LEN - 1) - idx)];
   endfunction

endpackage

// File: rtl/simon_ctrl_round_f.sv
// One combinational Simon round: Feistel mix of x into y with round key k.
module simon_round_f
   import simon_pkg::*;
(
   input  logic [WORD_W-1:0] x_i,
   input  logic [WORD_W-1:0] y_i,
   input  logic [WORD_W-1:0] k_i,
   output logic [WORD_W-1:0] x_o,
   output logic [WORD_W-1:0] y_o
);

   logic [WORD_W-1:0] rol1, rol2, rol8;

   assign rol1 = {x_i[WORD_W-2:0], x_i[WORD_W-1]};
   assign rol2 = {x_i[WORD_W-3:0], x_i[WORD_W-1:WORD_W-2]};
   assign rol8 = {x_i[WORD_W-9:0], x_i[WORD_W-1:WORD_W-8]};

   assign x_o = y_i ^ (rol1 & rol8) ^ rol2 ^ k_i;
   assign y_o = x_i;

endmodule

// File: rtl/simon_ctrl.sv
// Iterative Simon 128/128 encryptor: one round plus one key-schedule step per clock.
module simon_ctrl
   import simon_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [2*WORD_W-1:0] pt_i,
   input  logic [2*WORD_W-1:0] key_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [2*WORD_W-1:0] ct_o,
   output logic                busy_o,
   output logic [CNT_W-1:0]    round_o
);

   state_e              state_q;
   logic [WORD_W-1:0]   x_q, y_q, k0_q, k1_q;
   logic [WORD_W-1:0]   x_d, y_d, k1_d, t;
   logic [CNT_W-1:0]    cnt_q;
   logic                in_ready_q, busy_q, out_valid_q;

   simon_round_f u_round (
      .x_i (x_q),
      .y_i (y_q),
      .k_i (k0_q),
      .x_o (x_d),
      .y_o (y_d)
   );

   // k1' = ~k0 ^ 3 ^ z ^ ror3(k1) ^ ror4(k1); the ~ and ^3 are folded into C.
   assign t    = {k1_q[2:0], k1_q[WORD_W-1:3]} ^ {k1_q[3:0], k1_q[WORD_W-1:4]};
   assign k1_d = C ^ {{(WORD_W-1){1'b0}}, z2_bit(cnt_q)} ^ k0_q ^ t;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         k0_q        <= '0;
         k1_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid_i) begin
                  x_q        <= pt_i[2*WORD_W-1:WORD_W];
                  y_q        <= pt_i[WORD_W-1:0];
                  k0_q       <= key_i[WORD_W-1:0];
                  k1_q       <= key_i[2*WORD_W-1:WORD_W];
                  cnt_q      <= '0;
                  state_q    <= S_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_RUN: begin
               x_q  <= x_d;
               y_q  <= y_d;
               k0_q <= k1_q;
               k1_q <= k1_d;
               if (cnt_q == CNT_W'(NUM_ROUNDS - 1)) begin
                  cnt_q       <= '0;
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               // in_ready rises only after this edge, so no same-cycle re-accept.
               if (out_ready_i) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign busy_o      = busy_q;
   assign out_valid_o = out_valid_q;
   assign ct_o        = {x_q, y_q};
   assign round_o     = cnt_q;

endmodule
